gfx_layer_sel: RTL and testbench



---
 rtl/gfx_pkg.sv | 24 ++
 rtl/gfx_layer_sel_btn_debounce.sv | 49 ++++
 rtl/gfx_layer_sel.sv | 144 ++++++++++++++
 tb/tb_gfx_layer_sel.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/gfx_pkg.sv
// gfx_pkg: shared types, constants and helpers for the gfx layer selector.
package gfx_pkg;

    localparam int DEF_CW    = 8;
    localparam int DEF_N_SRC = 4;
    localparam int BORDER_W  = 4;

    typedef struct packed {
        logic [DEF_CW-1:0] r;
        logic [DEF_CW-1:0] g;
        logic [DEF_CW-1:0] b;
    } rgb_t;

    // Width needed to hold indices 0..n-1, never less than one bit.
    function automatic int clog2(input int n);
        int w;
        w = 0;
        while ((1 << w) < n) begin
            w = w + 1;
        end
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/gfx_layer_sel_btn_debounce.sv
// btn_debounce: two-flop synchroniser, stability counter, accepted level and
// a one-cycle press pulse on an accepted 0->1 transition.
module btn_debounce #(
    parameter int DB_CYCLES = 250000
) (
    input  logic clk,
    input  logic rst,
    input  logic i_btn,
    output logic o_press
);

    localparam int CNT_W = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_CYCLES - 1);

    logic             r_sync1;
    logic             r_sync2;
    logic             r_level;
    logic             r_press;
    logic [CNT_W-1:0] r_cnt;

    // Synchronise, then accept a new level only after it has held for DB_CYCLES clocks.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_level <= 1'b0;
            r_press <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_sync1 <= i_btn;
            r_sync2 <= r_sync1;
            r_press <= 1'b0;
            if (r_sync2 != r_level) begin
                if (r_cnt == CNT_MAX) begin
                    r_level <= r_sync2;
                    r_cnt   <= '0;
                    r_press <= r_sync2;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end else begin
                r_cnt <= '0;
            end
        end
    end

    assign o_press = r_press;

endmodule

// File: rtl/gfx_layer_sel.sv
// gfx_layer_sel: picks one of N_SRC RGB sources for the HDMI encoder, blanks
// pixels outside the visible frame, and applies source/invert changes only on
// a v_sync rising edge so a frame is never torn.
// Optional macro GFX_BORDER_EN: forces a BORDER_W-pixel all-ones frame border.
module gfx_layer_sel
    import gfx_pkg::*;
#(
    parameter int H_RES     = 1280,
    parameter int V_RES     = 720,
    parameter int CW        = DEF_CW,
    parameter int N_SRC     = DEF_N_SRC,
    parameter int DB_CYCLES = 250000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [15:0]             i_x,
    input  logic [15:0]             i_y,
    input  logic                    i_v_sync,
    input  logic [2:0]              i_btn,
    input  logic [N_SRC*3*CW-1:0]   i_src_rgb,
    output logic [clog2(N_SRC)-1:0] o_sel,
    output logic [CW-1:0]           o_red,
    output logic [CW-1:0]           o_green,
    output logic [CW-1:0]           o_blue
);

    localparam int SEL_W = clog2(N_SRC);
    localparam logic [SEL_W-1:0] SEL_MAX = SEL_W'(N_SRC - 1);
    localparam logic signed [15:0] H_S  = 16'(H_RES);
    localparam logic signed [15:0] V_S  = 16'(V_RES);

    logic [2:0]        w_press;
    logic [SEL_W-1:0]  r_pend_sel;
    logic              r_pend_inv;
    logic              r_act_inv;
    logic [SEL_W-1:0]  r_sel;
    logic              r_vs_d;
    logic [3*CW-1:0]   w_src;
    logic              w_in_frame;
    logic signed [15:0] w_x;
    logic signed [15:0] w_y;
    logic [3*CW-1:0]   r_s1_rgb;
    logic              r_s1_in;
    logic              r_s1_border;
    logic              w_border;
    logic [3*CW-1:0]   w_s2;
    logic [3*CW-1:0]   r_out;

    for (genvar gi = 0; gi < 3; gi++) begin : g_btn
        btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db (
            .clk     (clk),
            .rst     (rst),
            .i_btn   (i_btn[gi]),
            .o_press (w_press[gi])
        );
    end

    // Pending selection/invert follow presses; active copies load on v_sync rise.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pend_sel <= '0;
            r_pend_inv <= 1'b0;
            r_act_inv  <= 1'b0;
            r_sel      <= '0;
            r_vs_d     <= 1'b0;
        end else begin
            r_vs_d <= i_v_sync;
            if (w_press[0] && !w_press[1]) begin
                r_pend_sel <= (r_pend_sel == SEL_MAX) ? '0 : r_pend_sel + 1'b1;
            end else if (w_press[1] && !w_press[0]) begin
                r_pend_sel <= (r_pend_sel == '0) ? SEL_MAX : r_pend_sel - 1'b1;
            end
            if (w_press[2]) begin
                r_pend_inv <= ~r_pend_inv;
            end
            // A press on this same cycle only reaches pending, so it waits for the next edge.
            if (i_v_sync && !r_vs_d) begin
                r_sel     <= r_pend_sel;
                r_act_inv <= r_pend_inv;
            end
        end
    end

    // Source mux and frame-region decode for stage 1.
    always_comb begin
        w_src = '0;
        for (int k = 0; k < N_SRC; k++) begin
            if (r_sel == SEL_W'(k)) begin
                w_src = i_src_rgb[k*3*CW +: 3*CW];
            end
        end
        w_x = $signed(i_x);
        w_y = $signed(i_y);
        w_in_frame = (w_x >= 16'sd0) && (w_x < H_S) && (w_y >= 16'sd0) && (w_y < V_S);
`ifdef GFX_BORDER_EN
        w_border = (w_x < 16'(BORDER_W)) || (w_x >= 16'(H_RES - BORDER_W)) ||
                   (w_y < 16'(BORDER_W)) || (w_y >= 16'(V_RES - BORDER_W));
`else
        w_border = 1'b0;
`endif
    end

    // Stage 1: register selected pixel and region flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_rgb    <= '0;
            r_s1_in     <= 1'b0;
            r_s1_border <= 1'b0;
        end else begin
            r_s1_rgb    <= w_src;
            r_s1_in     <= w_in_frame;
            r_s1_border <= w_border;
        end
    end

    // Stage 2 value: blank, border, inverted or passthrough.
    always_comb begin
        w_s2 = '0;
        if (r_s1_in) begin
            if (r_s1_border) begin
                w_s2 = '1;
            end else if (r_act_inv) begin
                w_s2 = ~r_s1_rgb;
            end else begin
                w_s2 = r_s1_rgb;
            end
        end
    end

    // Stage 2: register the output pixel.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out <= '0;
        end else begin
            r_out <= w_s2;
        end
    end

    assign o_sel   = r_sel;
    assign o_red   = r_out[3*CW-1:2*CW];
    assign o_green = r_out[2*CW-1:CW];
    assign o_blue  = r_out[CW-1:0];

endmodule

// File: tb/tb_gfx_layer_sel.sv
// tb_gfx_layer_sel: randomized stimulus against a frame-level reference model.
module tb_gfx_layer_sel;

    localparam int H  = 1280;
    localparam int V  = 720;
    localparam int CW = 8;
    localparam int N  = 4;
    localparam int DB = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic [15:0]       x, y;
    logic              vs;
    logic [2:0]        btn;
    logic [N*3*CW-1:0] src;
    logic [1:0]        sel;
    logic [CW-1:0]     red, green, blue;

    always #5 clk = ~clk;

    gfx_layer_sel #(.H_RES(H), .V_RES(V), .CW(CW), .N_SRC(N), .DB_CYCLES(DB)) dut (
        .clk       (clk),
        .rst       (rst),
        .i_x       (x),
        .i_y       (y),
        .i_v_sync  (vs),
        .i_btn     (btn),
        .i_src_rgb (src),
        .o_sel     (sel),
        .o_red     (red),
        .o_green   (green),
        .o_blue    (blue)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    endtask

    // Reference state: what a viewer would see, independent of how it is built.
    int          m_sel, m_pend;
    bit          m_inv, m_pinv, m_vs_prev;
    logic [23:0] srcv [N];
    bit          const_src;
    logic [23:0] exp_d1;
    bit          exp_ok = 0;

    function automatic logic [23:0] pix(int xs, int ys, logic [23:0] v, bit inv);
        if (!(xs >= 0 && xs < H && ys >= 0 && ys < V)) return 24'h0;
`ifdef GFX_BORDER_EN
        if (xs < 4 || xs >= H - 4 || ys < 4 || ys >= V - 4) return 24'hFFFFFF;
`endif
        return inv ? ~v : v;
    endfunction

    function automatic int rcoord(int lim);
        case ($urandom_range(0, 11))
            0: return -1;
            1: return 0;
            2: return 3;
            3: return 4;
            4: return lim - 5;
            5: return lim - 4;
            6: return lim - 1;
            7: return lim;
            8: return -32768;
            default: return int'($urandom_range(0, lim + 40));
        endcase
    endfunction

    task automatic step(input bit r_in, input int xs, input int ys, input bit vs_in, input logic [2:0] b);
        logic [23:0] e;
        int su;
        for (int k = 0; k < N; k++) begin
            srcv[k] = const_src ? 24'(k * 32'h111111) : 24'($urandom);
            src[k*24 +: 24] = srcv[k];
        end
        rst = r_in; x = 16'(xs); y = 16'(ys); vs = vs_in; btn = b;
        if (r_in) begin
            m_sel = 0; m_pend = 0; m_inv = 0; m_pinv = 0; m_vs_prev = 0;
            e = 24'h0;
        end else begin
            su = m_sel;
            if (vs_in && !m_vs_prev) begin
                m_sel = m_pend;
                m_inv = m_pinv;
            end
            m_vs_prev = vs_in;
            e = pix(xs, ys, srcv[su], m_inv);
        end
        @(posedge clk);
        @(negedge clk);
        check("o_sel", 32'(sel), 32'(m_sel));
        if (r_in) check("rgb_in_reset", {8'h0, red, green, blue}, 32'h0);
        else if (exp_ok) check("rgb", {8'h0, red, green, blue}, {8'h0, exp_d1});
        exp_d1 = e;
        exp_ok = 1;
    endtask

    task automatic pix_steps(input int n);
        for (int i = 0; i < n; i++) step(0, rcoord(H), rcoord(V), 0, 3'b000);
    endtask

    // Hold a button mask for len cycles, then release long enough to settle.
    task automatic hold(input logic [2:0] mask, input int len);
        for (int i = 0; i < len; i++) step(0, rcoord(H), rcoord(V), 0, mask);
        pix_steps(8);
        if (len >= DB) begin
            if (mask[0] && !mask[1]) m_pend = (m_pend + 1) % N;
            if (mask[1] && !mask[0]) m_pend = (m_pend + N - 1) % N;
            if (mask[2]) m_pinv = !m_pinv;
        end
    endtask

    task automatic vsync_pulse();
        step(0, rcoord(H), rcoord(V), 1, 3'b000);
        step(0, rcoord(H), rcoord(V), 1, 3'b000);
        pix_steps(3);
    endtask

    initial begin
        const_src = 1;
        m_sel = 0; m_pend = 0; m_inv = 0; m_pinv = 0; m_vs_prev = 0;
        rst = 1; x = '0; y = '0; vs = 0; btn = '0; src = '0;
        for (int i = 0; i < 3; i++) step(1, 10, 10, 0, 3'b000);
        for (int i = 0; i < 4; i++) step(0, 10, 10, 0, 3'b000);
        hold(3'b001, 8);
        for (int i = 0; i < 3; i++) step(0, 10, 10, 0, 3'b000);
        vsync_pulse();
        for (int i = 0; i < 3; i++) step(0, 10, 10, 0, 3'b000);
        hold(3'b001, 3);
        vsync_pulse();
        hold(3'b010, 4);
        hold(3'b010, 6);
        vsync_pulse();
        hold(3'b001, 5);
        hold(3'b001, 5);
        vsync_pulse();
        hold(3'b011, 6);
        hold(3'b100, 6);
        vsync_pulse();
        step(0, 1280, 10, 0, 3'b000);
        step(0, -1, 10, 0, 3'b000);
        step(0, 10, 720, 0, 3'b000);
        step(0, 0, 10, 0, 3'b000);
        step(0, 1276, 10, 0, 3'b000);
        step(0, 4, 4, 0, 3'b000);
        step(0, 10, 10, 0, 3'b000);
        step(0, 10, 10, 0, 3'b000);
        const_src = 0;
        for (int p = 0; p < 60; p++) begin
            case ($urandom_range(0, 5))
                0: hold(3'($urandom_range(1, 7)), int'($urandom_range(1, 7)));
                1: hold(3'($urandom_range(1, 7)), int'($urandom_range(4, 7)));
                2: vsync_pulse();
                3: pix_steps(int'($urandom_range(1, 6)));
                4: begin
                    hold(3'($urandom_range(1, 7)), int'($urandom_range(4, 6)));
                    vsync_pulse();
                end
                default: begin
                    if (p % 15 == 7) begin
                        step(1, rcoord(H), rcoord(V), 0, 3'b000);
                        step(1, rcoord(H), rcoord(V), 0, 3'b000);
                    end
                    pix_steps(2);
                end
            endcase
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
